vec_seq_ctrl: RTL and testbench
===============================

Name: vec_seq_ctrl

Overview:
Multi-cycle sequencer for vector instructions (cond field 4'b1111) that drives the vector register file and vector ALU. The vector ALU produces LANES results per pass, so a vector of vlen elements is split into ceil(vlen/LANES) beats, each covering one register group. The sequencer latches the decoded instruction, issues the beats, generates the tail lane mask and accumulates flags. While it runs, it stalls the scalar PC/pipeline.

Parameters:
LANES, 5, results produced by the vector ALU per beat (width of lane_mask)
MAX_BEATS, 8, maximum beats per instruction
BEAT_W, 3, width of the beat counter (clog2 MAX_BEATS)
VLEN_W, 6, width of vlen; legal vlen is 1..LANES*MAX_BEATS (40)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  one-cycle request to execute a vector instruction
vd  in  4  destination base register
vn  in  4  source A base register
vm  in  4  source B base register
vlen  in  VLEN_W  element count
alu_ctrl  in  3  vector ALU operation, latched at start
wr_en  in  1  instruction writes results (0 = compare-only)
valu_flags  in  4  {N,Z,C,V} from the vector ALU for the current beat
stall  out  1  holds PC and scalar register writes
busy  out  1  sequencer not IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle illegal-vlen pulse
beat_idx  out  BEAT_W  current beat number
vrf_ra1  out  4  vector RF read address A
vrf_ra2  out  4  vector RF read address B
vrf_wa3  out  4  vector RF write address
vrf_we  out  1  vector RF write enable
lane_mask  out  LANES  per-lane write enable
valu_ctrl  out  3  latched alu_ctrl
flags_out  out  4  accumulated {N,Z,C,V}; valid while done=1

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE and every output goes to 0 immediately. This includes dropping vrf_we mid-write. Latched fields and flags clear. No partial completion is signalled.
- States: IDLE, READ, WRITE, FIN, ERR.
- IDLE: on start=1, latch vd, vn, vm, vlen, alu_ctrl and wr_en, and set beat=0.
  - If vlen==0 or vlen>LANES*MAX_BEATS, go to ERR.
  - Otherwise go to READ.
- READ: drive vrf_ra1=(vn+beat) mod 16 and vrf_ra2=(vm+beat) mod 16. Go to WRITE.
- WRITE: hold the read addresses and set vrf_wa3=(vd+beat) mod 16.
  - vrf_we=wr_en for this single cycle.
  - lane_mask = all ones, except on the last beat, where it is the low (vlen - LANES*beat) bits set.
  - Sample valu_flags this cycle.
  - If this is the last beat, go to FIN; otherwise beat+1 and go to READ.
- FIN: done=1 for one cycle, flags_out valid, then go to IDLE.
- ERR: err=1 and done=1 for one cycle, with no vrf_we and flags_out=0. Then go to IDLE.
- Latency: 2*beats+1 cycles from start to the done cycle inclusive (1 beat: start at T, done at T+3).
- stall = busy. It is asserted from the cycle after start through the FIN/ERR cycle.
- Flag accumulation:
  - Z = AND of Z over all beats.
  - N, C and V come from the last beat.
  - lane_mask, vrf_we and the addresses are 0 outside WRITE (addresses also valid in READ).
- start while busy is ignored; no queueing. start in the FIN cycle is also ignored, and start is accepted again in IDLE.
- Register indices wrap mod 16 (vn=15, beat 1 → register 0). Overlapping vd/vn ranges are not checked.
- beat_idx equals the beat counter in READ and WRITE, and is 0 otherwise.

Decomposition:
- Package vec_seq_pkg: state enumeration (IDLE, READ, WRITE, FIN, ERR), default LANES/MAX_BEATS, flag bit positions (N=3, Z=2, C=1, V=0).
- One sub-module, vec_tail_mask: combinational remaining-count → LANES-bit thermometer mask, saturating at all ones.
- FSM, counter and latches stay in vec_seq_ctrl.

Test Plan:
- vlen=5, vd=2, vn=4, vm=6, wr_en=1, start at T → READ at T+1 (ra1=4, ra2=6); WRITE at T+2 (wa3=2, vrf_we=1, lane_mask=11111); done at T+3; stall high T+1..T+3.
- vlen=12, vn=1 → 3 beats; ra1 = 1, 2, 3; masks 11111, 11111, 00011; done 7 cycles after start. Flags driven Z=1,1,0 → flags_out Z=0.
- vn=15, vd=14, vlen=10 → ra1 = 15 then 0; wa3 = 14 then 15 (wrap).
- vlen=0, then separately vlen=41 → cycle after start: err=1, done=1, vrf_we never asserted, back to IDLE.
- reset driven to 0 during the second WRITE of a 3-beat operation → vrf_we, stall and busy fall asynchronously. After release, no done pulse; a new start with vlen=5 completes normally.
- start re-pulsed during READ/WRITE, and wr_en=0 → second start ignored (single done); vrf_we stays 0 while lane_mask is still generated.

Source files
------------

// File: rtl/vec_seq_pkg.sv
// Shared definitions for the vector instruction sequencer.
// Provides default geometry, flag bit positions, the FSM state encoding
// and the latched-instruction payload.
package vec_seq_pkg;

   localparam int unsigned DEF_LANES     = 5;
   localparam int unsigned DEF_MAX_BEATS = 8;
   localparam int unsigned DEF_BEAT_W    = 3;
   localparam int unsigned DEF_VLEN_W    = 6;

   // Bit positions inside the {N,Z,C,V} flag nibble
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_FIN   = 3'd3,
      ST_ERR   = 3'd4
   } seq_state_e;

   // Decoded instruction fields held for the duration of the operation
   typedef struct packed {
      logic [3:0] vd;
      logic [3:0] vn;
      logic [3:0] vm;
      logic [2:0] alu_ctrl;
      logic       wr_en;
   } vec_instr_t;

endpackage

// File: rtl/vec_tail_mask.sv
// Remaining-element count to per-lane thermometer mask.
//   rem    : elements still to be written in this beat and later ones
//   mask_c : lane i enabled when rem > i; saturates to all ones
module vec_tail_mask #(
   parameter int unsigned LANES  = 5,
   parameter int unsigned VLEN_W = 6
) (
   input  logic [VLEN_W-1:0] rem,
   output logic [LANES-1:0]  mask_c
);

   always_comb begin
      mask_c = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         mask_c[i] = (32'(rem) > i);
      end
   end

endmodule

// File: rtl/vec_seq_ctrl.sv
// Multi-cycle sequencer for vector instructions.
// Splits a vlen-element operation into LANES-wide beats, each a READ cycle
// followed by a WRITE cycle, drives the vector RF/ALU, builds the tail lane
// mask, accumulates flags and stalls the scalar pipeline while running.
//   clk, reset (async, active low)
//   start, vd, vn, vm, vlen, alu_ctrl, wr_en : instruction request
//   valu_flags                               : per-beat {N,Z,C,V} from the ALU
//   stall, busy, done, err, beat_idx         : status
//   vrf_ra1, vrf_ra2, vrf_wa3, vrf_we        : vector RF control
//   lane_mask, valu_ctrl, flags_out          : ALU/write control and result flags
// All outputs are registered; next values are computed from the next state.
module vec_seq_ctrl
   import vec_seq_pkg::*;
#(
   parameter int unsigned LANES     = DEF_LANES,
   parameter int unsigned MAX_BEATS = DEF_MAX_BEATS,
   parameter int unsigned BEAT_W    = DEF_BEAT_W,
   parameter int unsigned VLEN_W    = DEF_VLEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        vd,
   input  logic [3:0]        vn,
   input  logic [3:0]        vm,
   input  logic [VLEN_W-1:0] vlen,
   input  logic [2:0]        alu_ctrl,
   input  logic              wr_en,
   input  logic [3:0]        valu_flags,
   output logic              stall,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [BEAT_W-1:0] beat_idx,
   output logic [3:0]        vrf_ra1,
   output logic [3:0]        vrf_ra2,
   output logic [3:0]        vrf_wa3,
   output logic              vrf_we,
   output logic [LANES-1:0]  lane_mask,
   output logic [2:0]        valu_ctrl,
   output logic [3:0]        flags_out
);

   localparam int unsigned MAX_VLEN = LANES * MAX_BEATS;

   seq_state_e        state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   vec_instr_t        instr_q, instr_d;
   logic [VLEN_W-1:0] vlen_q, vlen_d;
   logic              z_acc_q, z_acc_d;

   logic              stall_d, busy_d, done_d, err_d, vrf_we_d;
   logic [BEAT_W-1:0] beat_idx_d;
   logic [3:0]        vrf_ra1_d, vrf_ra2_d, vrf_wa3_d, flags_out_d;
   logic [LANES-1:0]  lane_mask_d;

   logic [VLEN_W-1:0] rem_q;
   logic [LANES-1:0]  tail_mask_c;
   logic              last_beat_c;

   // Elements left from the current beat onward; WRITE is always entered
   // from READ with beat/vlen unchanged, so the registered values suffice.
   assign rem_q       = vlen_q - VLEN_W'(LANES * beat_q);
   assign last_beat_c = (32'(rem_q) <= LANES);

   vec_tail_mask #(
      .LANES  (LANES),
      .VLEN_W (VLEN_W)
   ) u_tail_mask (
      .rem    (rem_q),
      .mask_c (tail_mask_c)
   );

   // Next state, counters, latches and next output values
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      instr_d     = instr_q;
      vlen_d      = vlen_q;
      z_acc_d     = z_acc_q;
      flags_out_d = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               instr_d.vd       = vd;
               instr_d.vn       = vn;
               instr_d.vm       = vm;
               instr_d.alu_ctrl = alu_ctrl;
               instr_d.wr_en    = wr_en;
               vlen_d           = vlen;
               beat_d           = '0;
               z_acc_d          = 1'b1;
               if ((vlen == '0) || (32'(vlen) > MAX_VLEN)) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            // Z is sticky-AND across beats; N, C, V follow the last beat
            z_acc_d = z_acc_q & valu_flags[FLAG_Z];
            if (last_beat_c) begin
               state_d             = ST_FIN;
               flags_out_d[FLAG_N] = valu_flags[FLAG_N];
               flags_out_d[FLAG_Z] = z_acc_q & valu_flags[FLAG_Z];
               flags_out_d[FLAG_C] = valu_flags[FLAG_C];
               flags_out_d[FLAG_V] = valu_flags[FLAG_V];
            end else begin
               beat_d  = beat_q + BEAT_W'(1);
               state_d = ST_READ;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d      = (state_d != ST_IDLE);
      stall_d     = busy_d;
      done_d      = 1'b0;
      err_d       = 1'b0;
      vrf_we_d    = 1'b0;
      beat_idx_d  = '0;
      vrf_ra1_d   = '0;
      vrf_ra2_d   = '0;
      vrf_wa3_d   = '0;
      lane_mask_d = '0;

      unique case (state_d)
         ST_READ: begin
            beat_idx_d = beat_d;
            vrf_ra1_d  = instr_d.vn + 4'(beat_d);
            vrf_ra2_d  = instr_d.vm + 4'(beat_d);
         end
         ST_WRITE: begin
            beat_idx_d  = beat_d;
            vrf_ra1_d   = instr_d.vn + 4'(beat_d);
            vrf_ra2_d   = instr_d.vm + 4'(beat_d);
            vrf_wa3_d   = instr_d.vd + 4'(beat_d);
            vrf_we_d    = instr_d.wr_en;
            lane_mask_d = tail_mask_c;
         end
         ST_FIN: begin
            done_d = 1'b1;
         end
         ST_ERR: begin
            done_d = 1'b1;
            err_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // State, latches and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         beat_q    <= '0;
         instr_q   <= '0;
         vlen_q    <= '0;
         z_acc_q   <= 1'b0;
         stall     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         beat_idx  <= '0;
         vrf_ra1   <= '0;
         vrf_ra2   <= '0;
         vrf_wa3   <= '0;
         vrf_we    <= 1'b0;
         lane_mask <= '0;
         valu_ctrl <= '0;
         flags_out <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         instr_q   <= instr_d;
         vlen_q    <= vlen_d;
         z_acc_q   <= z_acc_d;
         stall     <= stall_d;
         busy      <= busy_d;
         done      <= done_d;
         err       <= err_d;
         beat_idx  <= beat_idx_d;
         vrf_ra1   <= vrf_ra1_d;
         vrf_ra2   <= vrf_ra2_d;
         vrf_wa3   <= vrf_wa3_d;
         vrf_we    <= vrf_we_d;
         lane_mask <= lane_mask_d;
         valu_ctrl <= instr_d.alu_ctrl;
         flags_out <= flags_out_d;
      end
   end

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Directed self-checking bench for vec_seq_ctrl.
module tb_vec_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] vd, vn, vm;
   logic [5:0] vlen;
   logic [2:0] alu_ctrl;
   logic       wr_en;
   logic [3:0] valu_flags;
   logic       stall, busy, done, err;
   logic [2:0] beat_idx;
   logic [3:0] vrf_ra1, vrf_ra2, vrf_wa3;
   logic       vrf_we;
   logic [4:0] lane_mask;
   logic [2:0] valu_ctrl;
   logic [3:0] flags_out;

   int n_cmp = 0;
   int n_bad = 0;

   vec_seq_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .vd         (vd),
      .vn         (vn),
      .vm         (vm),
      .vlen       (vlen),
      .alu_ctrl   (alu_ctrl),
      .wr_en      (wr_en),
      .valu_flags (valu_flags),
      .stall      (stall),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .beat_idx   (beat_idx),
      .vrf_ra1    (vrf_ra1),
      .vrf_ra2    (vrf_ra2),
      .vrf_wa3    (vrf_wa3),
      .vrf_we     (vrf_we),
      .lane_mask  (lane_mask),
      .valu_ctrl  (valu_ctrl),
      .flags_out  (flags_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks every status/RF output; busy and stall share the expected value.
   task automatic chk_row(input string tag, input logic e_busy, input logic e_done,
                          input logic e_err, input logic e_we, input logic [4:0] e_mask,
                          input logic [3:0] e_ra1, input logic [3:0] e_ra2,
                          input logic [3:0] e_wa3, input logic [2:0] e_beat);
      chk({tag, ".stall"}, 32'(stall), 32'(e_busy));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      chk({tag, ".done"}, 32'(done), 32'(e_done));
      chk({tag, ".err"}, 32'(err), 32'(e_err));
      chk({tag, ".we"}, 32'(vrf_we), 32'(e_we));
      chk({tag, ".mask"}, 32'(lane_mask), 32'(e_mask));
      chk({tag, ".ra1"}, 32'(vrf_ra1), 32'(e_ra1));
      chk({tag, ".ra2"}, 32'(vrf_ra2), 32'(e_ra2));
      chk({tag, ".wa3"}, 32'(vrf_wa3), 32'(e_wa3));
      chk({tag, ".beat"}, 32'(beat_idx), 32'(e_beat));
   endtask

   // Pulses start for one cycle; returns in the cycle after start.
   task automatic do_start(input logic [3:0] i_vd, input logic [3:0] i_vn,
                           input logic [3:0] i_vm, input logic [5:0] i_vlen,
                           input logic [2:0] i_ctrl, input logic i_we);
      vd = i_vd; vn = i_vn; vm = i_vm; vlen = i_vlen;
      alu_ctrl = i_ctrl; wr_en = i_we; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; vd = '0; vn = '0; vm = '0; vlen = '0;
      alu_ctrl = '0; wr_en = 1'b0; valu_flags = '0;
      #3;
      chk_row("rst", 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      chk("rst.flags", 32'(flags_out), 32'h0);
      tick();
      reset = 1'b1;
      tick();
      chk_row("idle", 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);

      // Single beat, vlen = LANES
      do_start(4'd2, 4'd4, 4'd6, 6'd5, 3'd5, 1'b1);
      chk_row("t1.read", 1, 0, 0, 0, 5'b00000, 4, 6, 0, 0);
      chk("t1.ctrl", 32'(valu_ctrl), 32'd5);
      valu_flags = 4'b0110;
      tick();
      chk_row("t1.write", 1, 0, 0, 1, 5'b11111, 4, 6, 2, 0);
      tick();
      chk_row("t1.fin", 1, 1, 0, 0, 5'b00000, 0, 0, 0, 0);
      chk("t1.flags", 32'(flags_out), 32'b0110);
      tick();
      chk_row("t1.idle", 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);

      // Three beats, partial tail, Z cleared on last beat
      do_start(4'd8, 4'd1, 4'd3, 6'd12, 3'd2, 1'b1);
      for (int b = 0; b < 3; b++) begin
         chk_row($sformatf("t2.read%0d", b), 1, 0, 0, 0, 5'b00000,
                 4'(1 + b), 4'(3 + b), 0, 3'(b));
         valu_flags = (b == 2) ? 4'b1001 : 4'b0100;
         tick();
         chk_row($sformatf("t2.write%0d", b), 1, 0, 0, 1,
                 (b == 2) ? 5'b00011 : 5'b11111,
                 4'(1 + b), 4'(3 + b), 4'(8 + b), 3'(b));
         tick();
      end
      chk_row("t2.fin", 1, 1, 0, 0, 5'b00000, 0, 0, 0, 0);
      chk("t2.flags", 32'(flags_out), 32'b1001);
      tick();
      chk("t2.idle", 32'(busy), 32'd0);

      // Register index wrap
      valu_flags = 4'b0000;
      do_start(4'd14, 4'd15, 4'd0, 6'd10, 3'd1, 1'b1);
      chk_row("t3.read0", 1, 0, 0, 0, 5'b00000, 15, 0, 0, 0);
      tick();
      chk_row("t3.write0", 1, 0, 0, 1, 5'b11111, 15, 0, 14, 0);
      tick();
      chk_row("t3.read1", 1, 0, 0, 0, 5'b00000, 0, 1, 0, 1);
      tick();
      chk_row("t3.write1", 1, 0, 0, 1, 5'b11111, 0, 1, 15, 1);
      tick();
      chk("t3.done", 32'(done), 32'd1);
      chk("t3.flags", 32'(flags_out), 32'h0);
      tick();

      // Illegal lengths
      valu_flags = 4'b1111;
      do_start(4'd1, 4'd1, 4'd1, 6'd0, 3'd0, 1'b1);
      chk_row("t4.err0", 1, 1, 1, 0, 5'b00000, 0, 0, 0, 0);
      chk("t4.flags0", 32'(flags_out), 32'h0);
      tick();
      chk_row("t4.idle0", 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      do_start(4'd1, 4'd1, 4'd1, 6'd41, 3'd0, 1'b1);
      chk_row("t4.err41", 1, 1, 1, 0, 5'b00000, 0, 0, 0, 0);
      chk("t4.flags41", 32'(flags_out), 32'h0);
      tick();
      chk_row("t4.idle41", 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);

      // Maximum legal length: 8 beats, done 17 cycles after start
      do_start(4'd0, 4'd0, 4'd0, 6'd40, 3'd0, 1'b1);
      chk("t4.max.err", 32'(err), 32'd0);
      chk("t4.max.beat0", 32'(beat_idx), 32'd0);
      repeat (14) tick();
      chk("t4.max.beat7", 32'(beat_idx), 32'd7);
      tick();
      chk("t4.max.mask7", 32'(lane_mask), 32'b11111);
      chk("t4.max.wa7", 32'(vrf_wa3), 32'd7);
      tick();
      chk("t4.max.done", 32'(done), 32'd1);
      tick();

      // Asynchronous reset during second WRITE
      do_start(4'd0, 4'd5, 4'd9, 6'd15, 3'd4, 1'b1);
      tick();
      tick();
      chk("t5.read1.beat", 32'(beat_idx), 32'd1);
      tick();
      chk_row("t5.write1", 1, 0, 0, 1, 5'b11111, 6, 10, 1, 1);
      reset = 1'b0;
      #1;
      chk_row("t5.async", 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5.nodone%0d", i), 32'({done, busy}), 32'd0);
      end
      valu_flags = 4'b1110;
      do_start(4'd3, 4'd7, 4'd1, 6'd5, 3'd6, 1'b1);
      chk_row("t5.read", 1, 0, 0, 0, 5'b00000, 7, 1, 0, 0);
      tick();
      chk_row("t5.write", 1, 0, 0, 1, 5'b11111, 7, 1, 3, 0);
      tick();
      chk_row("t5.fin", 1, 1, 0, 0, 5'b00000, 0, 0, 0, 0);
      chk("t5.flags", 32'(flags_out), 32'b1110);
      tick();

      // Compare-only, restart attempts while busy and in FIN are ignored
      do_start(4'd4, 4'd2, 4'd2, 6'd7, 3'd3, 1'b0);
      vlen = 6'd5; vn = 4'd9; start = 1'b1;
      tick();
      chk_row("t6.write0", 1, 0, 0, 0, 5'b11111, 2, 2, 4, 0);
      chk("t6.ctrl", 32'(valu_ctrl), 32'd3);
      tick();
      start = 1'b0;
      chk_row("t6.read1", 1, 0, 0, 0, 5'b00000, 3, 3, 0, 1);
      tick();
      chk_row("t6.write1", 1, 0, 0, 0, 5'b00011, 3, 3, 5, 1);
      tick();
      chk_row("t6.fin", 1, 1, 0, 0, 5'b00000, 0, 0, 0, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_row("t6.idle", 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
      tick();
      chk_row("t6.still_idle", 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
